// File: rtl/and_tree_sequencer_pkg.sv
// Shared types and helpers for the time-multiplexed AND-reduction engine.
package and_tree_sequencer_pkg;

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] REDUCE_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE_ENC,
    ST_REDUCE = REDUCE_ENC,
    ST_DONE   = DONE_ENC
  } state_t;

  // Ceiling log2, usable in parameter defaults.
  function automatic int tree_log2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/and_gate.sv
// Two-input AND cell, the single shared operator of the reduction engine.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/and_tree_sequencer.sv
// Sequential balanced-tree AND reduction: one shared and_gate, one tree
// operation per cycle, valid/ready on both sides.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for an operand vector, in_ready high
// ST_REDUCE | one in-place tree op per edge, N_LEAVES-1 ops in total
// ST_DONE   | result presented on out_data until out_ready
module and_tree_sequencer
  import and_tree_sequencer_pkg::*;
#(
  parameter int N_LEAVES = 8,
  parameter int CNT_W    = tree_log2(N_LEAVES) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_LEAVES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_data,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  localparam int LVL_W = tree_log2(N_LEAVES);

  state_t              state, state_nxt;
  logic [N_LEAVES-1:0] scratch;
  logic [LVL_W-1:0]    lvl, idx;
  logic [LVL_W-1:0]    a_idx, b_idx;
  logic                gate_y;
  logic                accept;
  logic                last_op;
  logic                level_end;

  assign accept    = (state == ST_IDLE) && in_valid;
  assign level_end = (idx == lvl - LVL_W'(1));
  assign last_op   = (state == ST_REDUCE) && (lvl == LVL_W'(1));

  // Sources 2*idx and 2*idx+1 always sit at or above idx, so the
  // write-back to idx never clobbers an operand still to be read this level.
  assign a_idx = idx << 1;
  assign b_idx = a_idx | LVL_W'(1);

  and_gate u_gate (
    .a (scratch[a_idx]),
    .b (scratch[b_idx]),
    .y (gate_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_REDUCE;
      end
      ST_REDUCE: begin
        busy = 1'b1;
        if (last_op) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = scratch[0];
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch  <= '0;
      lvl      <= '0;
      idx      <= '0;
      op_count <= '0;
    end else if (accept) begin
      scratch  <= in_data;
      lvl      <= LVL_W'(N_LEAVES / 2);
      idx      <= '0;
      op_count <= '0;
    end else if (state == ST_REDUCE) begin
      scratch[idx] <= gate_y;
      op_count     <= op_count + CNT_W'(1);
      if (level_end) begin
        lvl <= lvl >> 1;
        idx <= '0;
      end else begin
        idx <= idx + LVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_and_tree_sequencer.sv
// Self-checking bench: N=8 and N=2 instances, table vectors, random vectors
// against an AND-of-leaves / fixed-latency model, and corner sequences.
module tb_and_tree_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N = 8 instance
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] in_data8 = '0;
  logic       out_data8, busy8;
  logic [3:0] op_count8;

  and_tree_sequencer #(.N_LEAVES(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .busy(busy8), .op_count(op_count8)
  );

  // N = 2 instance
  logic       in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [1:0] in_data2 = '0;
  logic       out_data2, busy2;
  logic [1:0] op_count2;

  and_tree_sequencer #(.N_LEAVES(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .busy(busy2), .op_count(op_count2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         stall;
    bit         pulse;
    logic       exp;
  } vec_t;

  vec_t vt[8];

  // One full N=8 transaction; expectations come from the AND of all leaves
  // and the fixed 7-op schedule.
  task automatic run8(input logic [7:0] d, input int stall, input bit pulse,
                      input bit rnd_ready, input logic exp);
    chk("idle_in_ready", int'(in_ready8), 1);
    in_valid8 = 1'b1;
    in_data8  = d;
    step();
    in_valid8 = 1'b0;
    in_data8  = 8'($urandom);
    chk("accept_busy", int'(busy8), 1);
    chk("accept_in_ready", int'(in_ready8), 0);
    chk("accept_op_count", int'(op_count8), 0);
    for (int k = 1; k <= 7; k++) begin
      if (pulse && k == 2) begin
        in_valid8 = 1'b1;
        in_data8  = 8'h00;
      end
      out_ready8 = rnd_ready ? 1'($urandom) : 1'b0;
      if (k == 7) out_ready8 = 1'b0;
      step();
      in_valid8 = 1'b0;
      chk("reduce_op_count", int'(op_count8), k);
      chk("reduce_out_valid", int'(out_valid8), (k == 7) ? 1 : 0);
    end
    chk("done_out_data", int'(out_data8), int'(exp));
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_out_valid", int'(out_valid8), 1);
      chk("stall_out_data", int'(out_data8), int'(exp));
      chk("stall_op_count", int'(op_count8), 7);
    end
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    chk("post_in_ready", int'(in_ready8), 1);
    chk("post_out_valid", int'(out_valid8), 0);
    chk("post_busy", int'(busy8), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1;
    logic [7:0] rd;

    vt[0] = '{8'hFF, 0, 1'b0, 1'b1};
    vt[1] = '{8'hDF, 0, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 5, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 0, 1'b1, 1'b1};
    vt[4] = '{8'h00, 2, 1'b0, 1'b0};
    vt[5] = '{8'h7F, 1, 1'b0, 1'b0};
    vt[6] = '{8'hFE, 0, 1'b1, 1'b0};
    vt[7] = '{8'hFB, 3, 1'b0, 1'b0};

    rst = 1'b1;
    step();
    step();
    chk("rst_in_ready8", int'(in_ready8), 1);
    chk("rst_out_valid8", int'(out_valid8), 0);
    chk("rst_out_data8", int'(out_data8), 0);
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_op_count8", int'(op_count8), 0);
    chk("rst_in_ready2", int'(in_ready2), 1);
    chk("rst_busy2", int'(busy2), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      run8(vt[i].data, vt[i].stall, vt[i].pulse, 1'b0, vt[i].exp);

    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      if (i % 3 == 0) rd = 8'hFF;
      run8(rd, int'($urandom_range(0, 3)), 1'($urandom), 1'b1, &rd);
    end

    // Reset on the third REDUCE edge aborts the vector.
    in_valid8 = 1'b1;
    in_data8  = 8'hFF;
    step();
    in_valid8 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready8), 1);
    chk("abort_out_valid", int'(out_valid8), 0);
    chk("abort_out_data", int'(out_data8), 0);
    chk("abort_busy", int'(busy8), 0);
    chk("abort_op_count", int'(op_count8), 0);

    // Reset together with in_valid captures nothing.
    rst       = 1'b1;
    in_valid8 = 1'b1;
    in_data8  = 8'hFF;
    step();
    rst       = 1'b0;
    in_valid8 = 1'b0;
    chk("rstvalid_busy", int'(busy8), 0);
    chk("rstvalid_in_ready", int'(in_ready8), 1);
    step();
    chk("rstvalid_still_idle", int'(busy8), 0);

    run8(8'hFF, 0, 1'b0, 1'b0, 1'b1);

    // N=2: single op, back-to-back with initiation interval 3.
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    in_data2   = 2'b11;
    step();
    c0 = cyc;
    in_data2 = 2'b10;
    chk("n2_accept_out_valid", int'(out_valid2), 0);
    chk("n2_accept_in_ready", int'(in_ready2), 0);
    step();
    chk("n2_first_out_valid", int'(out_valid2), 1);
    chk("n2_first_out_data", int'(out_data2), 1);
    chk("n2_first_op_count", int'(op_count2), 1);
    step();
    chk("n2_idle_in_ready", int'(in_ready2), 1);
    chk("n2_idle_out_valid", int'(out_valid2), 0);
    step();
    c1 = cyc;
    in_valid2 = 1'b0;
    chk("n2_initiation_interval", c1 - c0, 3);
    step();
    chk("n2_second_out_valid", int'(out_valid2), 1);
    chk("n2_second_out_data", int'(out_data2), 0);
    step();
    chk("n2_end_in_ready", int'(in_ready2), 1);
    out_ready2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
